// File: rtl/sfp_pkg.sv
// Shared types and helpers for the multi-pass SFP accumulator.
// Lane widths derive from the psum width and the runtime packing mode.
package sfp_pkg;

   localparam int unsigned COL_DEF     = 8;
   localparam int unsigned PSUM_BW_DEF = 16;
   localparam int unsigned LEN_BW_DEF  = 8;

   typedef enum logic [1:0] {
      MODE_X1 = 2'd0,
      MODE_X2 = 2'd1,
      MODE_X4 = 2'd2
   } act_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_e;

   // Mode 3 behaves as a single full-width lane.
   function automatic int unsigned lane_width(input int unsigned psum_bw, input logic [1:0] mode);
      case (mode)
         2'd1:    return psum_bw / 2;
         2'd2:    return psum_bw / 4;
         default: return psum_bw;
      endcase
   endfunction

endpackage

// File: rtl/sfp_multi_acc_if.sv
// Job control, psum input and FIFO-side output bundle of the SFP accumulator.
interface sfp_multi_acc_if
   import sfp_pkg::*;
#(
   parameter int unsigned COL     = COL_DEF,
   parameter int unsigned PSUM_BW = PSUM_BW_DEF,
   parameter int unsigned LEN_BW  = LEN_BW_DEF
);
   logic                     start;
   logic [LEN_BW-1:0]        acc_len;
   logic [1:0]               act_mode;
   logic                     relu_en;
   logic [PSUM_BW*COL-1:0]   in_psum;
   logic [COL-1:0]           valid_in;
   logic                     ofifo_full;
   logic [PSUM_BW*COL-1:0]   out_accum;
   logic [COL-1:0]           wr_ofifo;
   logic                     o_valid;
   logic                     busy;
   logic                     done;
   logic                     ovf_err;

   modport master (
      output start, acc_len, act_mode, relu_en, in_psum, valid_in, ofifo_full,
      input  out_accum, wr_ofifo, o_valid, busy, done, ovf_err
   );

   modport slave (
      input  start, acc_len, act_mode, relu_en, in_psum, valid_in, ofifo_full,
      output out_accum, wr_ofifo, o_valid, busy, done, ovf_err
   );
endinterface

// File: rtl/sfp_lane_add.sv
// One column's segmented signed adder: 1, 2 or 4 independent lanes, no inter-lane carry.
// SFP_SAT_EN defined: each lane saturates to its min/max; otherwise lanes wrap.
module sfp_lane_add
   import sfp_pkg::*;
#(
   parameter int unsigned PSUM_BW = PSUM_BW_DEF
) (
   input  logic [PSUM_BW-1:0] i_a,
   input  logic [PSUM_BW-1:0] i_b,
   input  logic [1:0]         i_mode,
   output logic [PSUM_BW-1:0] o_sum_c
);

   logic [2:0][PSUM_BW-1:0] w_res;

   for (genvar m = 0; m < 3; m++) begin : g_mode
      localparam int unsigned W  = lane_width(PSUM_BW, 2'(m));
      localparam int unsigned NL = PSUM_BW / W;
      for (genvar l = 0; l < NL; l++) begin : g_lane
         logic [W-1:0] w_lane;
`ifdef SFP_SAT_EN
         // Sign-extended sum: top two bits differing means the lane overflowed.
         logic [W:0] w_ext;
         assign w_ext  = {i_a[l*W+W-1], i_a[l*W +: W]} + {i_b[l*W+W-1], i_b[l*W +: W]};
         assign w_lane = (w_ext[W] == w_ext[W-1]) ? w_ext[W-1:0] :
                         (w_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
`else
         assign w_lane = i_a[l*W +: W] + i_b[l*W +: W];
`endif
         assign w_res[m][l*W +: W] = w_lane;
      end
   end

   always_comb begin
      o_sum_c = w_res[0];
      case (i_mode)
         MODE_X2: o_sum_c = w_res[1];
         MODE_X4: o_sum_c = w_res[2];
         default: o_sum_c = w_res[0];
      endcase
   end

endmodule

// File: rtl/sfp_multi_acc.sv
// Multi-pass per-column psum accumulator with lane packing, optional ReLU and FIFO backpressure.
// SFP_SAT_EN selects saturating instead of wrapping lane arithmetic (see sfp_lane_add).
module sfp_multi_acc
   import sfp_pkg::*;
#(
   parameter int unsigned COL     = COL_DEF,
   parameter int unsigned PSUM_BW = PSUM_BW_DEF,
   parameter int unsigned LEN_BW  = LEN_BW_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   sfp_multi_acc_if.slave  bus
);

   localparam logic [1:0]  S_IDLE  = IDLE;
   localparam logic [1:0]  S_ACCUM = ACCUM;
   localparam logic [1:0]  S_OUT   = OUT;
   localparam int unsigned W2      = lane_width(PSUM_BW, 2'(MODE_X2));
   localparam int unsigned W4      = lane_width(PSUM_BW, 2'(MODE_X4));

   logic [1:0]                    r_state;
   logic [1:0]                    w_state_nxt;
   logic [LEN_BW-1:0]             r_len;
   logic [1:0]                    r_mode;
   logic                          r_relu;
   logic [COL-1:0][PSUM_BW-1:0]   r_acc;
   logic [COL-1:0][LEN_BW-1:0]    r_cnt;
   logic [COL-1:0][PSUM_BW-1:0]   w_sum;
   logic [COL-1:0][PSUM_BW-1:0]   w_relu;
   logic [COL-1:0]                w_col_done;
   logic [PSUM_BW*COL-1:0]        r_out;
   logic [COL-1:0]                r_wr;
   logic                          r_done;
   logic                          r_ovf;
   logic                          r_busy;
   logic                          r_o_valid;
   logic                          w_start_ok;
   logic                          w_write;

   for (genvar k = 0; k < COL; k++) begin : g_col
      sfp_lane_add #(.PSUM_BW(PSUM_BW)) u_add (
         .i_a     (r_acc[k]),
         .i_b     (bus.in_psum[k*PSUM_BW +: PSUM_BW]),
         .i_mode  (r_mode),
         .o_sum_c (w_sum[k])
      );
      assign w_col_done[k] = (r_cnt[k] == r_len);
   end

   assign w_start_ok = (r_state == S_IDLE) && bus.start;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state; a zero-length job skips straight to the write
   always_comb begin
      w_state_nxt = r_state;
      w_write     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_nxt = (bus.acc_len == '0) ? S_OUT : S_ACCUM;
         end
         S_ACCUM: begin
            if (&w_col_done) w_state_nxt = S_OUT;
         end
         S_OUT: begin
            if (!bus.ofifo_full) begin
               w_write     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Per-lane ReLU on the accumulated value
   always_comb begin
      w_relu = r_acc;
      if (r_relu) begin
         for (int unsigned k = 0; k < COL; k++) begin
            case (r_mode)
               MODE_X2: begin
                  for (int unsigned l = 0; l < 2; l++)
                     if (r_acc[k][l*W2+W2-1]) w_relu[k][l*W2 +: W2] = '0;
               end
               MODE_X4: begin
                  for (int unsigned l = 0; l < 4; l++)
                     if (r_acc[k][l*W4+W4-1]) w_relu[k][l*W4 +: W4] = '0;
               end
               default: begin
                  if (r_acc[k][PSUM_BW-1]) w_relu[k] = '0;
               end
            endcase
         end
      end
   end

   // Job configuration, accumulation, overflow flag and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_len     <= '0;
         r_mode    <= '0;
         r_relu    <= 1'b0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_out     <= '0;
         r_wr      <= '0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_busy    <= 1'b0;
         r_o_valid <= 1'b0;
      end else begin
         r_wr      <= '0;
         r_done    <= 1'b0;
         r_o_valid <= 1'b0;
         r_busy    <= (w_state_nxt != S_IDLE);
         if (w_start_ok) begin
            r_len  <= bus.acc_len;
            r_mode <= bus.act_mode;
            r_relu <= bus.relu_en;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
         end else if (r_state == S_ACCUM) begin
            for (int unsigned k = 0; k < COL; k++) begin
               if (bus.valid_in[k]) begin
                  if (!w_col_done[k]) begin
                     r_acc[k] <= w_sum[k];
                     r_cnt[k] <= r_cnt[k] + LEN_BW'(1);
                  end else begin
                     r_ovf <= 1'b1;
                  end
               end
            end
         end
         if (w_write) begin
            r_out     <= w_relu;
            r_wr      <= '1;
            r_done    <= 1'b1;
            r_o_valid <= 1'b1;
         end
      end
   end

   assign bus.out_accum = r_out;
   assign bus.wr_ofifo  = r_wr;
   assign bus.o_valid   = r_o_valid;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.ovf_err   = r_ovf;

endmodule
